// File: rtl/hazard_irq_ctrl_pkg.sv
// hazard_irq_ctrl_pkg: state encoding, PCSrc codes and counter helper shared with ID.
package hazard_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        IRQ_HOLD = 2'd2
    } state_e;

    localparam logic [2:0] PCSRC_SEQ    = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_IRQ    = 3'd3;
    localparam logic [2:0] PCSRC_EXC    = 3'd4;

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_irq_ctrl_hazard_detect.sv
// hazard_detect: number of stall cycles the ID instruction needs for hazards forwarding cannot cover.
module hazard_detect #(
    parameter int LOAD_BR_STALL = 2
) (
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       use_rt_i,
    input  logic       branch_i,
    input  logic       jump_i,
    input  logic       jr_i,
    input  logic       mem_read_ex_i,
    input  logic       reg_write_ex_i,
    input  logic [4:0] wa_ex_i,
    input  logic       mem_read_mem_i,
    input  logic [4:0] wa_mem_i,
    output logic [1:0] n_o
);
    logic rt_used, is_br, plain, m_ex, m_mem, n_one, n_long;

    // jr/jalr read rs only, whatever the rt field happens to hold
    assign rt_used = use_rt_i & ~jr_i;
    assign is_br   = branch_i | jr_i;
    assign plain   = ~branch_i & ~jump_i;
    assign m_ex    = (rs_i != 5'd0 && rs_i == wa_ex_i) || (rt_used && rt_i != 5'd0 && rt_i == wa_ex_i);
    assign m_mem   = (rs_i != 5'd0 && rs_i == wa_mem_i) || (rt_used && rt_i != 5'd0 && rt_i == wa_mem_i);
    assign n_long  = is_br & mem_read_ex_i & m_ex;
    assign n_one   = (plain & mem_read_ex_i & reg_write_ex_i & m_ex)
                   | (is_br & reg_write_ex_i & ~mem_read_ex_i & m_ex)
                   | (is_br & mem_read_mem_i & m_mem);
    assign n_o     = n_long ? 2'(LOAD_BR_STALL) : n_one ? 2'd1 : 2'd0;

endmodule

// File: rtl/hazard_irq_ctrl.sv
// hazard_irq_ctrl: ID-stage stall/bubble sequencing plus safe-point interrupt and exception flushes.
module hazard_irq_ctrl
    import hazard_irq_ctrl_pkg::*;
#(
    parameter int LOAD_BR_STALL = 2,
    parameter int IRQ_HOLDOFF   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsaddrID,
    input  logic [4:0]  rtaddrID,
    input  logic        useRtID,
    input  logic        BranchID,
    input  logic        JumpID,
    input  logic        JRID,
    input  logic        exceptionID,
    input  logic [31:0] PCID,
    input  logic        MemReadEX,
    input  logic        RegWriteEX,
    input  logic [4:0]  regwriteaddrEX,
    input  logic        MemReadMEM,
    input  logic [4:0]  regwriteaddrMEM,
    input  logic        irq,
    output logic        stall,
    output logic        flushIDEX,
    output logic        flushIFID,
    output logic        intterupt,
    output logic        irq_pending
);
    if (LOAD_BR_STALL < 1 || LOAD_BR_STALL > 3) begin : g_bad_lbs
        $error("LOAD_BR_STALL must be 1..3");
    end
    if (IRQ_HOLDOFF < 0 || IRQ_HOLDOFF > 3) begin : g_bad_hold
        $error("IRQ_HOLDOFF must be 0..3");
    end

    state_e     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d, holdoff_q, holdoff_d, n;
    logic       pend_q, pend_d, prev_xfer_q, prev_xfer_d;
    logic       hz, take, exc, user, pc_unused;

    hazard_detect #(.LOAD_BR_STALL(LOAD_BR_STALL)) u_hd (
        .rs_i          (rsaddrID),
        .rt_i          (rtaddrID),
        .use_rt_i      (useRtID),
        .branch_i      (BranchID),
        .jump_i        (JumpID),
        .jr_i          (JRID),
        .mem_read_ex_i (MemReadEX),
        .reg_write_ex_i(RegWriteEX),
        .wa_ex_i       (regwriteaddrEX),
        .mem_read_mem_i(MemReadMEM),
        .wa_mem_i      (regwriteaddrMEM),
        .n_o           (n)
    );

    assign user      = ~PCID[31];
    assign pc_unused = ^PCID[30:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= 2'd0;
            holdoff_q   <= 2'd0;
            pend_q      <= 1'b0;
            prev_xfer_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            holdoff_q   <= holdoff_d;
            pend_q      <= pend_d;
            prev_xfer_q <= prev_xfer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = hz ? n - 2'd1 : stall_cnt_q;
        if (state_q == STALL) begin
            stall_cnt_d = sat_dec(stall_cnt_q);
            state_d     = (stall_cnt_q <= 2'd1) ? RUN : STALL;
        end else if (hz && n > 2'd1) begin
            state_d = STALL;
        end else if (take) begin
            state_d = IRQ_HOLD;
        end else if (state_q == IRQ_HOLD && holdoff_q <= 2'd1) begin
            state_d = RUN;
        end
        holdoff_d   = take ? 2'(IRQ_HOLDOFF) : sat_dec(holdoff_q);
        pend_d      = take ? 1'b0 : (irq & user) ? 1'b1 : pend_q;
        prev_xfer_d = flushIFID ? 1'b0 : stall ? prev_xfer_q : (BranchID | JumpID);
    end

    // outputs are forced low while reset is held, even with hazard inputs active
    always_comb begin
        hz          = n != 2'd0;
        stall       = reset & ((state_q == STALL) | hz);
        take        = reset & (state_q == RUN) & ~hz & pend_q & ~prev_xfer_q & user & (holdoff_q == 2'd0);
        exc         = reset & exceptionID & user & ~stall & ~take;
        flushIDEX   = stall | take | exc;
        flushIFID   = take | exc;
        intterupt   = take;
        irq_pending = pend_q;
    end

endmodule

// File: tb/tb_hazard_irq_ctrl.sv
// tb_hazard_irq_ctrl: scoreboard bench; expected {stall,flushIDEX,flushIFID,intterupt,irq_pending} queued per cycle.
module tb_hazard_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsaddrID, rtaddrID, regwriteaddrEX, regwriteaddrMEM;
    logic        useRtID, BranchID, JumpID, JRID, exceptionID;
    logic [31:0] PCID;
    logic        MemReadEX, RegWriteEX, MemReadMEM, irq;
    logic        stall, flushIDEX, flushIFID, intterupt, irq_pending;

    typedef struct {
        string      tag;
        logic [4:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    hazard_irq_ctrl #(.LOAD_BR_STALL(2), .IRQ_HOLDOFF(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .rsaddrID       (rsaddrID),
        .rtaddrID       (rtaddrID),
        .useRtID        (useRtID),
        .BranchID       (BranchID),
        .JumpID         (JumpID),
        .JRID           (JRID),
        .exceptionID    (exceptionID),
        .PCID           (PCID),
        .MemReadEX      (MemReadEX),
        .RegWriteEX     (RegWriteEX),
        .regwriteaddrEX (regwriteaddrEX),
        .MemReadMEM     (MemReadMEM),
        .regwriteaddrMEM(regwriteaddrMEM),
        .irq            (irq),
        .stall          (stall),
        .flushIDEX      (flushIDEX),
        .flushIFID      (flushIFID),
        .intterupt      (intterupt),
        .irq_pending    (irq_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b (stall,fIDEX,fIFID,int,pend)", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.tag, {stall, flushIDEX, flushIFID, intterupt, irq_pending}, e.val);
        end
    end

    task automatic idle_in();
        rsaddrID = 5'd0; rtaddrID = 5'd0; useRtID = 1'b0; BranchID = 1'b0; JumpID = 1'b0; JRID = 1'b0;
        exceptionID = 1'b0; PCID = 32'h0040_0000; MemReadEX = 1'b0; RegWriteEX = 1'b0;
        regwriteaddrEX = 5'd0; MemReadMEM = 1'b0; regwriteaddrMEM = 5'd0; irq = 1'b0;
    endtask

    task automatic tick(input string tag, input logic [4:0] val);
        exp_t x;
        x.tag = tag;
        x.val = val;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic lw_ex(input logic [4:0] r);
        MemReadEX = 1'b1; RegWriteEX = 1'b1; regwriteaddrEX = r;
    endtask

    initial begin
        idle_in();
        reset = 1'b0;
        @(posedge clk); #1;
        tick("rst", 5'b00000);
        reset = 1'b1;
        tick("idle", 5'b00000);
        // load-use on rs, then the lw moves on
        lw_ex(5'd2); rsaddrID = 5'd2;
        tick("lu_rs", 5'b11000);
        idle_in(); MemReadMEM = 1'b1; regwriteaddrMEM = 5'd2; rsaddrID = 5'd2;
        tick("lu_done", 5'b00000);
        idle_in(); lw_ex(5'd7); rtaddrID = 5'd7;
        tick("lu_rt_unused", 5'b00000);
        useRtID = 1'b1;
        tick("lu_rt_used", 5'b11000);
        idle_in(); lw_ex(5'd0);
        tick("lu_r0", 5'b00000);
        // branch on a load result: two counted stall cycles
        idle_in(); BranchID = 1'b1; rsaddrID = 5'd3; lw_ex(5'd3);
        tick("blw1", 5'b11000);
        MemReadEX = 1'b0; RegWriteEX = 1'b0; MemReadMEM = 1'b1; regwriteaddrMEM = 5'd3;
        tick("blw2", 5'b11000);
        MemReadMEM = 1'b0;
        tick("blw3", 5'b00000);
        idle_in();
        tick("blw_slot", 5'b00000);
        // branch on ALU result in EX via rt
        BranchID = 1'b1; useRtID = 1'b1; rtaddrID = 5'd4; RegWriteEX = 1'b1; regwriteaddrEX = 5'd4;
        tick("balu", 5'b11000);
        RegWriteEX = 1'b0;
        tick("balu_done", 5'b00000);
        // jr ignores rt
        idle_in(); JumpID = 1'b1; JRID = 1'b1; useRtID = 1'b1; rtaddrID = 5'd5; RegWriteEX = 1'b1; regwriteaddrEX = 5'd5;
        tick("jr_rt", 5'b00000);
        rsaddrID = 5'd5;
        tick("jr_rs", 5'b11000);
        idle_in(); BranchID = 1'b1; rsaddrID = 5'd6; MemReadMEM = 1'b1; regwriteaddrMEM = 6;
        tick("bmem", 5'b11000);
        idle_in();
        tick("idle2", 5'b00000);
        tick("idle3", 5'b00000);
        // delay slot blocks take, then take, then holdoff blocks the next one
        BranchID = 1'b1; irq = 1'b1;
        tick("ds_br", 5'b00000);
        idle_in();
        tick("ds_block", 5'b00001);
        tick("take", 5'b01111);
        irq = 1'b1;
        tick("hold0", 5'b00000);
        irq = 1'b0;
        tick("hold1", 5'b00001);
        tick("take2", 5'b01111);
        tick("h2a", 5'b00000);
        tick("h2b", 5'b00000);
        tick("h2c", 5'b00000);
        // kernel mode ignores irq
        PCID = 32'h8000_0040; irq = 1'b1;
        tick("kern1", 5'b00000);
        tick("kern2", 5'b00000);
        idle_in();
        tick("kern_after", 5'b00000);
        // pending irq waits for the load-use stall
        irq = 1'b1;
        tick("irq_set", 5'b00000);
        irq = 1'b0; lw_ex(5'd2); rsaddrID = 5'd2;
        tick("irq_lu", 5'b11001);
        idle_in();
        tick("irq_after", 5'b01111);
        tick("h3a", 5'b00000);
        tick("h3b", 5'b00000);
        // take beats exception; exception seen afterwards
        irq = 1'b1;
        tick("irq_set2", 5'b00000);
        irq = 1'b0; exceptionID = 1'b1; PCID = 32'h0040_0010;
        tick("exc_take", 5'b01111);
        tick("exc_flush", 5'b01100);
        PCID = 32'h8000_0000;
        tick("exc_kern", 5'b00000);
        idle_in();
        tick("h4", 5'b00000);
        // reset asserted mid-STALL
        BranchID = 1'b1; rsaddrID = 5'd3; lw_ex(5'd3); irq = 1'b1;
        tick("rs_stall", 5'b11000);
        reset = 1'b0;
        tick("rst_mid", 5'b00000);
        reset = 1'b1; idle_in();
        tick("rst_after", 5'b00000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_irq_ctrl.md
Name: hazard_irq_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the ID stage and detects the load-use and branch/jump-register operand hazards that forwarding cannot resolve, then holds PC and IF/ID and injects EX bubbles for the required number of cycles. It also latches external interrupt requests and releases them to ID as a one-cycle pulse, only at a safe point: no stall, not a delay slot, user mode. It drives the flush controls for interrupt and exception redirects.

Parameters:
LOAD_BR_STALL, 2, stall cycles when a branch/JR operand comes from a load in EX.
IRQ_HOLDOFF, 2, cycles after an interrupt is taken during which a new take is blocked, so the kernel PC can reach ID.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
rsaddrID  in  5  ID rs field
rtaddrID  in  5  ID rt field
useRtID  in  1  ID instruction reads rt (R-type, branch, store)
BranchID  in  1  ID is a conditional branch
JumpID  in  1  ID is j/jal/jr/jalr
JRID  in  1  ID is jr/jalr
exceptionID  in  1  ID undefined-opcode exception
PCID  in  32  PC of ID instruction; bit 31 = kernel mode
MemReadEX  in  1  EX instruction is a load
RegWriteEX  in  1  EX writes a register
regwriteaddrEX  in  5  EX destination
MemReadMEM  in  1  MEM instruction is a load
regwriteaddrMEM  in  5  MEM destination
irq  in  1  external interrupt request, level
stall  out  1  hold PC and IF/ID; also fed to Control to zero ID controls
flushIDEX  out  1  load bubble into ID/EX
flushIFID  out  1  clear IF/ID
intterupt  out  1  one-cycle interrupt-take pulse to ID (PCSrc=3)
irq_pending  out  1  latched request, status/debug

Behaviour:
- Reset (reset=0, async): state RUN, stall_cnt=0, holdoff_cnt=0, irq_pending=0, prev_xfer=0. All outputs are 0.
- Hazard detection, combinational on current inputs. A register matches if its address is nonzero and equals the destination. rt counts only when useRtID=1, except that JR uses rs only.
  - Load-use (not a branch or jump): MemReadEX & RegWriteEX & match(EX) -> N=1.
  - Branch/JR: RegWriteEX & !MemReadEX & match(EX) -> N=1.
  - Branch/JR: MemReadEX & match(EX) -> N=LOAD_BR_STALL.
  - Branch/JR: MemReadMEM & match(MEM) -> N=1. ALUoutMEM forwarding does not cover load data.
  - If several rules apply, N = max.
- FSM states: RUN, STALL, IRQ_HOLD.
  - RUN, hazard N>0: stall=1, flushIDEX=1 this cycle. stall_cnt<=N-1. Go to STALL if N>1, else stay in RUN; the hazard is re-evaluated next cycle.
  - STALL: stall=1, flushIDEX=1, stall_cnt decrements. Go to RUN when stall_cnt==1.
  - Reset mid-stall aborts to RUN.
- Delay-slot tracking: prev_xfer <= BranchID|JumpID when stall=0. prev_xfer holds during stall and clears on a flushIFID cycle.
- Interrupt latch: irq_pending set on any cycle with irq=1 & PCID[31]=0. Cleared only by the take.
- Take condition: state RUN & no hazard & irq_pending & !prev_xfer & PCID[31]=0 & holdoff_cnt=0.
  - On take: intterupt=1 for exactly one cycle, flushIFID=1, flushIDEX=1.
  - Next cycle: irq_pending=0, state IRQ_HOLD, holdoff_cnt=IRQ_HOLDOFF.
- IRQ_HOLD: decrement holdoff_cnt; go to RUN at 0. Hazards are still serviced in this state (stall wins); holdoff continues counting.
- Exception: exceptionID & PCID[31]=0 & no hazard & no take -> flushIFID=1, flushIDEX=1 for one cycle. Interrupt take has priority over exception in the same cycle; the exception re-occurs after return.
- Priority, highest first: reset, hazard stall, interrupt take, exception flush.
- Counters are 2 bits and saturate.
- Misconfiguration (LOAD_BR_STALL outside 1..3, or IRQ_HOLDOFF outside 0..3) triggers an elaboration error.

Decomposition:
Shared package holds the FSM state encoding (RUN=0, STALL=1, IRQ_HOLD=2) and the PCSrc codes (0 seq, 1 branch, 2 jump, 3 irq, 4 exc) shared with ID. One sub-module, hazard_detect (purely combinational N computation), keeps the FSM readable and is unit-testable alone.

Test Plan:
- lw $2 in EX (MemReadEX=1, regwriteaddrEX=2), add in ID with rs=2 -> stall=1 and flushIDEX=1 for 1 cycle, then 0.
- lw $3 in EX, beq rs=3 in ID -> stall for 2 consecutive cycles. Next cycle, with the lw now in MEM, no further stall beyond the counted 2.
- Interrupt in delay slot: BranchID=1 accepted, irq=1 next cycle -> no take that cycle. Take one cycle later: intterupt pulse width 1, flushIFID=1, irq_pending then 0.
- irq=1 with PCID=0x8000_0040 -> irq_pending stays 0, intterupt never asserted.
- irq_pending=1 and load-use hazard in the same cycle -> stall first, intterupt one cycle after stall ends. After a take, a second irq is blocked for IRQ_HOLDOFF=2 cycles.
- exceptionID=1, PCID=0x0040_0010, irq_pending=1 in the same cycle -> intterupt=1 and no exception flush. Assert reset low mid-STALL -> all outputs 0 immediately.
